// File: rtl/data_mem_initiator.sv
// Load/store initiator for a stall-handshake data memory port (strobe, then clk_stall rise/fall).
// Optional macro MISALIGN_CHECK_EN rejects misaligned half/word requests with rsp_err and issues no strobe.
module data_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic             we_q, we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_write_data_q, mem_write_data_d;
    logic [3:0]       mem_sign_mask_q, mem_sign_mask_d;
    logic             mem_memread_q, mem_memread_d;
    logic             mem_memwrite_q, mem_memwrite_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             req_ready_s;
    logic             accept_s;
    logic             misalign_s;

    function automatic logic [3:0] build_mask(input logic [1:0] size, input logic sgn);
        logic [3:0] mask;
        case (size)
            2'd0:    mask = {sgn, 3'b001};
            2'd1:    mask = {sgn, 3'b011};
            default: mask = {sgn, 3'b111};
        endcase
        return mask;
    endfunction

`ifdef MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            default: bad = (addr_lo != 2'd0);
        endcase
        return bad;
    endfunction

    assign misalign_s = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Never accept while the memory is still busy, e.g. finishing a transaction dropped by reset.
    assign req_ready_s = (state_q == IDLE) && !mem_clk_stall;
    assign accept_s    = req_valid && req_ready_s;
    assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and registered-output computation for the transaction sequencer.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        we_d             = we_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_sign_mask_d  = mem_sign_mask_q;
        mem_memread_d    = 1'b0;
        mem_memwrite_d   = 1'b0;
        rsp_valid_d      = 1'b0;
        rsp_err_d        = 1'b0;
        rsp_rdata_d      = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    we_d             = req_we;
                    mem_addr_d       = req_addr;
                    mem_write_data_d = req_wdata;
                    mem_sign_mask_d  = build_mask(req_size, req_signed);
                    cnt_d            = {CNT_W{1'b0}};
                    if (misalign_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = IDLE;
                    end else begin
                        mem_memread_d  = !req_we;
                        mem_memwrite_d = req_we;
                        state_d        = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                cnt_d = cnt_inc_s;
                if (cnt_inc_s >= TIMEOUT_LIM) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                    state_d     = IDLE;
                end else if (mem_clk_stall) begin
                    state_d = WAIT_LO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                cnt_d = cnt_inc_s;
                if (!mem_clk_stall) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'd0 : mem_read_data;
                    state_d     = IDLE;
                end else if (cnt_inc_s >= TIMEOUT_LIM) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                    state_d     = IDLE;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= {CNT_W{1'b0}};
            we_q             <= 1'b0;
            mem_addr_q       <= 32'd0;
            mem_write_data_q <= 32'd0;
            mem_sign_mask_q  <= 4'd0;
            mem_memread_q    <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_err_q        <= 1'b0;
            rsp_rdata_q      <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            we_q             <= we_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_sign_mask_q  <= mem_sign_mask_d;
            mem_memread_q    <= mem_memread_d;
            mem_memwrite_q   <= mem_memwrite_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_err_q        <= rsp_err_d;
            rsp_rdata_q      <= rsp_rdata_d;
        end
    end

    assign req_ready      = req_ready_s;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_sign_mask  = mem_sign_mask_q;
    assign mem_memread    = mem_memread_q;
    assign mem_memwrite   = mem_memwrite_q;

endmodule
